dense_neuron_mac: RTL and testbench

Per-neuron multiply-accumulate stage of the dense layer. It sits directly upstream of the tanh activation LUT. It consumes a stream of (activation, weight) pairs in signed Q(N-Q-1).Q fixed point and accumulates their products at extended width. It then adds a bias, saturates to N bits, and presents one pre-activation word per neuron to the activation stage over a valid/ready handshake.

---
 rtl/dense_neuron_mac.sv | 141 ++++++++++++++
 tb/tb_dense_neuron_mac.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_neuron_mac.sv
// dense_neuron_mac
// Per-neuron multiply-accumulate stage ahead of the tanh activation LUT.
// Accepts a stream of (activation, weight) beats in signed Q(N-Q-1).Q,
// accumulates the Q-aligned products at ACC_W bits, adds the neuron bias on
// the terminating beat, saturates to N bits and holds the result on a
// valid/ready output until the activation stage takes it.
module dense_neuron_mac #(
  parameter int N      = 32,
  parameter int Q      = 16,
  parameter int ACC_W  = 48,
  parameter int MAX_IN = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [N-1:0] in_weight,
  input  logic         in_last,
  input  logic [N-1:0] bias,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_sat,
  output logic         out_trunc
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Beat counter only has to reach MAX_IN-1.
  localparam int CNT_W = (MAX_IN > 1) ? $clog2(MAX_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_IN - 1);

  // Two guard bits above the accumulator so acc + product + bias can never
  // wrap before the saturation compare.
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] SAT_POS = {{(SUM_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_NEG = {{(SUM_W-N+1){1'b1}}, {(N-1){1'b0}}};

  state_t                   r_state;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic signed [ACC_W-1:0]  r_acc;
  logic        [CNT_W-1:0]  r_cnt;
  logic        [N-1:0]      r_out_data;
  logic                     r_out_sat;
  logic                     r_out_trunc;

  logic signed [2*N-1:0]    w_prod_full;
  logic signed [2*N-1:0]    w_prod_shr;
  logic signed [ACC_W-1:0]  w_prod;
  logic signed [SUM_W-1:0]  w_sum;
  logic                     w_accept;
  logic                     w_term;
  logic                     w_pos_ovf;
  logic                     w_neg_ovf;
  logic        [N-1:0]      w_sat_data;

  // Full-precision product; both operands are signed so the multiply is
  // sign-extended to 2N bits before it is formed.
  assign w_prod_full = $signed(in_data) * $signed(in_weight);

  // Re-align to Q fractional bits; arithmetic shift floors toward -inf.
  assign w_prod_shr  = w_prod_full >>> Q;

  // NOTE: a part-select is always unsigned; assigning it to a signed net
  // restores the signed interpretation without changing the bits.
  assign w_prod      = w_prod_shr[ACC_W-1:0];

  assign w_accept    = in_valid && r_in_ready;
  assign w_term      = in_last || (r_cnt == CNT_LAST);

  // Final sum for the terminating beat, evaluated at guard width.
  assign w_sum = {{2{r_acc[ACC_W-1]}}, r_acc}
               + {{2{w_prod[ACC_W-1]}}, w_prod}
               + {{(SUM_W-N){bias[N-1]}}, bias};

  assign w_pos_ovf  = (w_sum > SAT_POS);
  assign w_neg_ovf  = (w_sum < SAT_NEG);
  assign w_sat_data = w_pos_ovf ? {1'b0, {(N-1){1'b1}}} :
                      w_neg_ovf ? {1'b1, {(N-1){1'b0}}} :
                                  w_sum[N-1:0];

  // Neuron FSM: accumulate beats in ACCUM, present the result in HOLD.
  // NOTE: every state register uses non-blocking assignment so all of them
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_trunc <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (w_term) begin
              r_out_data  <= w_sat_data;
              r_out_sat   <= w_pos_ovf || w_neg_ovf;
              r_out_trunc <= !in_last;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= HOLD;
            end else begin
              r_acc <= r_acc + w_prod;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= ACCUM;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_trunc = r_out_trunc;

endmodule

// File: tb/tb_dense_neuron_mac.sv
// Testbench for dense_neuron_mac (instantiated with MAX_IN=4 so the beat
// limit is reachable). Directed scenarios use hand-computed constants; the
// random scenario uses a plain-integer arithmetic model of a neuron.
module tb_dense_neuron_mac;

  localparam int N      = 32;
  localparam int Q      = 16;
  localparam int ACC_W  = 48;
  localparam int MAX_IN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [N-1:0]  in_weight;
  logic          in_last;
  logic [N-1:0]  bias;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_sat;
  logic          out_trunc;

  int n_checks = 0;
  int n_errors = 0;

  // Beats of the neuron currently being modelled.
  logic [31:0] md [MAX_IN];
  logic [31:0] mw [MAX_IN];

  dense_neuron_mac #(
    .N(N), .Q(Q), .ACC_W(ACC_W), .MAX_IN(MAX_IN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_weight (in_weight),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  // Drive one beat for one edge, then return the bus to idle with junk data.
  task automatic drive_beat(input logic [31:0] d, input logic [31:0] w,
                            input logic last, input logic [31:0] b);
    in_valid  = 1'b1;
    in_data   = d;
    in_weight = w;
    in_last   = last;
    bias      = b;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_last   = 1'($urandom);
    in_data   = $urandom;
    in_weight = $urandom;
    bias      = $urandom;
  endtask

  // Wait (bounded) for a result, capture it, and complete one transfer.
  task automatic pop_result(output logic [31:0] d, output logic s,
                            output logic t, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    d = out_data;
    s = out_sat;
    t = out_trunc;
    if (ok) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  // Reference neuron: exact integer sum of floor-shifted products plus bias,
  // then clipped to the signed 32-bit range.
  function automatic void model(input int nb, input logic [31:0] b,
                                output logic [31:0] d, output logic s);
    longint sum;
    longint lim_hi;
    longint lim_lo;
    sum    = longint'($signed(b));
    lim_hi = 64'sd2147483647;
    lim_lo = -64'sd2147483648;
    for (int i = 0; i < nb; i++)
      sum += (longint'($signed(md[i])) * longint'($signed(mw[i]))) >>> Q;
    if (sum > lim_hi) begin
      d = 32'h7FFF_FFFF; s = 1'b1;
    end else if (sum < lim_lo) begin
      d = 32'h8000_0000; s = 1'b1;
    end else begin
      d = sum[31:0]; s = 1'b0;
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_data = '0; in_weight = '0; bias = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 ||
        out_sat !== 1'b0 || out_trunc !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h sat=%b trunc=%b, want 1 0 00000000 0 0",
               in_ready, out_valid, out_data, out_sat, out_trunc);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic s, t, ok;
    drive_beat(32'h0001_0000, 32'h0000_8000, 1'b0, $urandom);
    drive_beat(32'h0001_0000, 32'h0000_8000, 1'b0, $urandom);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL basic_early_valid: got %b want 0", out_valid);
    end
    drive_beat(32'h0001_0000, 32'h0000_8000, 1'b1, 32'h0000_4000);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_latency: vld=%b rdy=%b want 1 0", out_valid, in_ready);
    end
    pop_result(d, s, t, ok);
    n_checks++;
    if (!ok || d !== 32'h0001_C000 || s !== 1'b0 || t !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_result: ok=%b data=%h sat=%b trunc=%b want 0001c000 0 0", ok, d, s, t);
    end
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_signed_floor();
    logic [31:0] d; logic s, t, ok;
    drive_beat(32'hFFFE_0000, 32'h0001_8000, 1'b1, 32'h0);
    pop_result(d, s, t, ok);
    n_checks++;
    if (!ok || d !== 32'hFFFD_0000 || s !== 1'b0) begin
      n_errors++; $display("FAIL signed_mul: ok=%b data=%h sat=%b want fffd0000 0", ok, d, s);
    end
    drive_beat(32'hFFFF_FFFF, 32'h0000_8000, 1'b1, 32'h0);
    pop_result(d, s, t, ok);
    n_checks++;
    if (!ok || d !== 32'hFFFF_FFFF || s !== 1'b0) begin
      n_errors++; $display("FAIL floor_shift: ok=%b data=%h sat=%b want ffffffff 0", ok, d, s);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] d; logic s, t, ok;
    drive_beat(32'h7FFF_0000, 32'h7FFF_0000, 1'b1, 32'h0);
    pop_result(d, s, t, ok);
    n_checks++;
    if (!ok || d !== 32'h7FFF_FFFF || s !== 1'b1) begin
      n_errors++; $display("FAIL sat_pos: ok=%b data=%h sat=%b want 7fffffff 1", ok, d, s);
    end
    drive_beat(32'h8001_0000, 32'h7FFF_0000, 1'b1, 32'h0);
    pop_result(d, s, t, ok);
    n_checks++;
    if (!ok || d !== 32'h8000_0000 || s !== 1'b1) begin
      n_errors++; $display("FAIL sat_neg: ok=%b data=%h sat=%b want 80000000 1", ok, d, s);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic s, t, ok;
    drive_beat(32'h0002_0000, 32'h0001_8000, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_last = 1'b1;
      in_data = 32'h0001_0000; in_weight = 32'h0001_0000; bias = 32'h0100_0000;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h0003_0000) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b data=%h want 1 0 00030000",
                 i, out_valid, in_ready, out_data);
      end
    end
    in_valid = 1'b0;
    pop_result(d, s, t, ok);
    n_checks++;
    if (!ok || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_release: ok=%b rdy=%b vld=%b want 1 1 0", ok, in_ready, out_valid);
    end
    // Any beat leaked in during HOLD would corrupt this neuron.
    drive_beat(32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0);
    pop_result(d, s, t, ok);
    n_checks++;
    if (!ok || d !== 32'h0001_0000) begin
      n_errors++; $display("FAIL bp_no_leak: ok=%b data=%h want 00010000", ok, d);
    end
  endtask

  task automatic test_max_in();
    logic [31:0] d; logic s, t, ok;
    for (int i = 0; i < MAX_IN; i++)
      drive_beat(32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++; $display("FAIL maxin_term: vld=%b want 1", out_valid);
    end
    pop_result(d, s, t, ok);
    n_checks++;
    if (!ok || d !== 32'h0004_0000 || t !== 1'b1 || s !== 1'b0) begin
      n_errors++;
      $display("FAIL maxin_result: ok=%b data=%h trunc=%b sat=%b want 00040000 1 0", ok, d, t, s);
    end
    drive_beat(32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0);
    pop_result(d, s, t, ok);
    n_checks++;
    if (!ok || d !== 32'h0001_0000 || t !== 1'b0) begin
      n_errors++; $display("FAIL maxin_next: ok=%b data=%h trunc=%b want 00010000 0", ok, d, t);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic s, t, ok;
    drive_beat(32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0);
    drive_beat(32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0);
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    drive_beat(32'h0002_0000, 32'h0001_0000, 1'b1, 32'h0);
    pop_result(d, s, t, ok);
    n_checks++;
    if (!ok || d !== 32'h0002_0000 || t !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid: ok=%b data=%h trunc=%b want 00020000 0", ok, d, t);
    end
    drive_beat(32'h0003_0000, 32'h0001_0000, 1'b1, 32'h0);
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_hold: vld=%b rdy=%b data=%h want 0 1 00000000", out_valid, in_ready, out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic s, t, ok;
    out_ready = 1'b1;
    drive_beat(32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0001_0000) begin
      n_errors++; $display("FAIL b2b_first: vld=%b data=%h want 1 00010000", out_valid, out_data);
    end
    // Offered during the transfer cycle; must not be taken.
    drive_beat(32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL b2b_transfer: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    out_ready = 1'b0;
    drive_beat(32'h0002_0000, 32'h0001_0000, 1'b1, 32'h0);
    pop_result(d, s, t, ok);
    n_checks++;
    if (!ok || d !== 32'h0002_0000) begin
      n_errors++; $display("FAIL b2b_second: ok=%b data=%h want 00020000", ok, d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, exp_d, b; logic s, t, ok, exp_s, exp_t;
    int nb, sel;
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(1, MAX_IN + 2));
      nb  = (sel > MAX_IN) ? MAX_IN : sel;
      exp_t = (sel > MAX_IN);
      b = 32'(int'($urandom_range(0, 32'h00FF_FFFF)) - 32'sh0080_0000);
      for (int i = 0; i < nb; i++) begin
        md[i] = 32'(int'($urandom_range(0, 32'h00FF_FFFF)) - 32'sh0080_0000);
        mw[i] = 32'(int'($urandom_range(0, 32'h00FF_FFFF)) - 32'sh0080_0000);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        drive_beat(md[i], mw[i], (i == nb - 1) && !exp_t,
                   (i == nb - 1) ? b : $urandom);
      end
      model(nb, b, exp_d, exp_s);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      pop_result(d, s, t, ok);
      n_checks++;
      if (!ok || d !== exp_d || s !== exp_s || t !== exp_t) begin
        n_errors++;
        $display("FAIL random[%0d]: ok=%b data=%h sat=%b trunc=%b want %h %b %b",
                 n, ok, d, s, t, exp_d, exp_s, exp_t);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_signed_floor();
    test_saturation();
    test_backpressure();
    test_max_in();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
